// File: rtl/divider_4bit.sv
// rtl/divider_4bit.sv - sequential unsigned 4-bit restoring divider with start/done handshake
// One quotient bit per clock, MSB first; divide-by-zero completes in the idle cycle.
module divider_4bit (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [3:0] dividend,
  input  logic [3:0] divisor,
  output logic [3:0] quotient,
  output logic [3:0] remainder,
  output logic       busy,
  output logic       done,
  output logic       div_by_zero
);

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

  state_t     state, state_n;
  logic [1:0] cnt, cnt_n;
  logic [3:0] dvd, dvd_n;
  logic [3:0] dsr, dsr_n;
  logic [4:0] rem, rem_n;
  logic [3:0] quotient_n, remainder_n;
  logic       done_n, dbz_n;
  logic [5:0] diff;
  logic       qbit;

  // dvd doubles as the quotient shift register: dividend bits leave at the top
  // while quotient bits enter at the bottom.
  assign diff = {rem, dvd[3]} - {2'b00, dsr};
  assign qbit = ~diff[5];
  assign busy = (state == BUSY);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      cnt         <= 2'd0;
      dvd         <= 4'd0;
      dsr         <= 4'd0;
      rem         <= 5'd0;
      quotient    <= 4'd0;
      remainder   <= 4'd0;
      done        <= 1'b0;
      div_by_zero <= 1'b0;
    end else begin
      state       <= state_n;
      cnt         <= cnt_n;
      dvd         <= dvd_n;
      dsr         <= dsr_n;
      rem         <= rem_n;
      quotient    <= quotient_n;
      remainder   <= remainder_n;
      done        <= done_n;
      div_by_zero <= dbz_n;
    end
  end

  always_comb begin
    state_n     = state;
    cnt_n       = cnt;
    dvd_n       = dvd;
    dsr_n       = dsr;
    rem_n       = rem;
    quotient_n  = quotient;
    remainder_n = remainder;
    done_n      = 1'b0;
    dbz_n       = div_by_zero;
    case (state)
      IDLE: begin
        if (start) begin
          if (divisor == 4'd0) begin
            quotient_n  = 4'hF;
            remainder_n = dividend;
            dbz_n       = 1'b1;
            done_n      = 1'b1;
          end else begin
            dvd_n   = dividend;
            dsr_n   = divisor;
            rem_n   = 5'd0;
            cnt_n   = 2'd0;
            state_n = BUSY;
          end
        end
      end
      BUSY: begin
        rem_n = qbit ? diff[4:0] : {rem[3:0], dvd[3]};
        dvd_n = {dvd[2:0], qbit};
        cnt_n = cnt + 2'd1;
        if (cnt == 2'd3) begin
          quotient_n  = dvd_n;
          remainder_n = rem_n[3:0];
          dbz_n       = 1'b0;
          done_n      = 1'b1;
          state_n     = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

endmodule

// File: tb/tb_divider_4bit.sv
// tb/tb_divider_4bit.sv - directed and exhaustive self-checking bench for divider_4bit
module tb_divider_4bit;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [3:0] dividend;
  logic [3:0] divisor;
  logic [3:0] quotient;
  logic [3:0] remainder;
  logic       busy;
  logic       done;
  logic       div_by_zero;

  int pass_cnt = 0;
  int total_cnt = 0;
  int overlap_cnt = 0;

  divider_4bit dut (
    .clk(clk),
    .rst_n(rst_n),
    .start(start),
    .dividend(dividend),
    .divisor(divisor),
    .quotient(quotient),
    .remainder(remainder),
    .busy(busy),
    .done(done),
    .div_by_zero(div_by_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) if (rst_n && busy && done) overlap_cnt++;

  // Launches one operation and returns the number of edges after the accepting
  // edge until done is seen (0 for divide-by-zero), or -1 on timeout.
  task automatic run_div(input logic [3:0] a, input logic [3:0] b,
                         output logic [3:0] q, output logic [3:0] r,
                         output logic z, output int lat);
    @(negedge clk);
    start = 1'b1; dividend = a; divisor = b;
    @(posedge clk); #1;
    start = 1'b0; dividend = 4'($urandom); divisor = 4'($urandom);
    lat = 0;
    while (!done && lat < 10) begin
      @(posedge clk); #1;
      lat++;
    end
    if (!done) lat = -1;
    q = quotient; r = remainder; z = div_by_zero;
  endtask

  task automatic test_reset();
    int seen;
    rst_n = 1'b0; start = 1'b0; dividend = 4'd0; divisor = 4'd0;
    repeat (2) @(posedge clk);
    #1;
    total_cnt++;
    if ({quotient, remainder, busy, done, div_by_zero} !== 11'd0)
      $display("FAIL reset_initial: got q=%0d r=%0d busy=%b done=%b dbz=%b, want all 0",
               quotient, remainder, busy, done, div_by_zero);
    else pass_cnt++;
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
    start = 1'b1; dividend = 4'd13; divisor = 4'd4;
    @(posedge clk); #1; start = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    total_cnt++;
    if (busy !== 1'b1) $display("FAIL reset_pre_busy: got busy=%b, want 1", busy);
    else pass_cnt++;
    #2 rst_n = 1'b0;
    #1;
    total_cnt++;
    if ({quotient, remainder, busy, done, div_by_zero} !== 11'd0)
      $display("FAIL reset_midop: got q=%0d r=%0d busy=%b done=%b dbz=%b, want all 0",
               quotient, remainder, busy, done, div_by_zero);
    else pass_cnt++;
    @(negedge clk); rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (done || busy) seen++;
    end
    total_cnt++;
    if (seen !== 0) $display("FAIL reset_no_done: got %0d busy/done cycles, want 0", seen);
    else pass_cnt++;
  endtask

  task automatic test_basic();
    logic [3:0] q, r;
    logic z;
    int lat;
    run_div(4'd13, 4'd4, q, r, z, lat);
    total_cnt++;
    if (lat !== 4) $display("FAIL basic_latency: got %0d, want 4", lat);
    else pass_cnt++;
    total_cnt++;
    if ({q, r, z} !== {4'd3, 4'd1, 1'b0})
      $display("FAIL basic_13_4: got q=%0d r=%0d dbz=%b, want q=3 r=1 dbz=0", q, r, z);
    else pass_cnt++;
    @(posedge clk); #1;
    total_cnt++;
    if (done !== 1'b0 || quotient !== 4'd3 || remainder !== 4'd1)
      $display("FAIL basic_pulse_hold: got done=%b q=%0d r=%0d, want done=0 q=3 r=1",
               done, quotient, remainder);
    else pass_cnt++;
  endtask

  task automatic test_extremes();
    logic [3:0] ta [4] = '{4'd15, 4'd3, 4'd0, 4'd15};
    logic [3:0] tb [4] = '{4'd1, 4'd7, 4'd5, 4'd15};
    logic [3:0] tq [4] = '{4'd15, 4'd0, 4'd0, 4'd1};
    logic [3:0] tr [4] = '{4'd0, 4'd3, 4'd0, 4'd0};
    logic [3:0] q, r;
    logic z;
    int lat;
    for (int i = 0; i < 4; i++) begin
      run_div(ta[i], tb[i], q, r, z, lat);
      total_cnt++;
      if (lat !== 4 || q !== tq[i] || r !== tr[i] || z !== 1'b0)
        $display("FAIL extreme_%0d_%0d: got lat=%0d q=%0d r=%0d dbz=%b, want lat=4 q=%0d r=%0d dbz=0",
                 ta[i], tb[i], lat, q, r, z, tq[i], tr[i]);
      else pass_cnt++;
    end
  endtask

  task automatic test_div_zero();
    logic [3:0] q, r;
    logic z;
    int lat;
    int busy_seen;
    busy_seen = 0;
    fork
      run_div(4'd9, 4'd0, q, r, z, lat);
      begin
        repeat (3) begin
          @(negedge clk);
          if (busy) busy_seen++;
        end
      end
    join
    total_cnt++;
    if (lat !== 0 || {q, r, z} !== {4'd15, 4'd9, 1'b1})
      $display("FAIL dbz_9_0: got lat=%0d q=%0d r=%0d dbz=%b, want lat=0 q=15 r=9 dbz=1",
               lat, q, r, z);
    else pass_cnt++;
    total_cnt++;
    if (busy_seen !== 0) $display("FAIL dbz_busy: got %0d busy cycles, want 0", busy_seen);
    else pass_cnt++;
    run_div(4'd8, 4'd3, q, r, z, lat);
    total_cnt++;
    if (lat !== 4 || {q, r, z} !== {4'd2, 4'd2, 1'b0})
      $display("FAIL dbz_after_8_3: got lat=%0d q=%0d r=%0d dbz=%b, want lat=4 q=2 r=2 dbz=0",
               lat, q, r, z);
    else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    int k;
    @(negedge clk);
    start = 1'b1; dividend = 4'd14; divisor = 4'd3;
    @(posedge clk); #1; start = 1'b0;
    @(negedge clk);
    start = 1'b1; dividend = 4'd6; divisor = 4'd2;
    @(posedge clk); #1; start = 1'b0; dividend = 4'd0; divisor = 4'd0;
    k = 1;
    while (!done && k < 10) begin
      @(posedge clk); #1;
      k++;
    end
    total_cnt++;
    if (k !== 4 || quotient !== 4'd4 || remainder !== 4'd2 || div_by_zero !== 1'b0)
      $display("FAIL busy_start_ignored: got lat=%0d q=%0d r=%0d dbz=%b, want lat=4 q=4 r=2 dbz=0",
               k, quotient, remainder, div_by_zero);
    else pass_cnt++;
    @(negedge clk);
    start = 1'b1; dividend = 4'd6; divisor = 4'd2;
    @(posedge clk); #1; start = 1'b0;
    k = 1;
    total_cnt++;
    if (busy !== 1'b1) $display("FAIL done_cycle_accept: got busy=%b, want 1", busy);
    else pass_cnt++;
    while (!done && k < 12) begin
      @(posedge clk); #1;
      k++;
    end
    total_cnt++;
    if (k !== 5 || quotient !== 4'd3 || remainder !== 4'd0)
      $display("FAIL back_to_back_6_2: got spacing=%0d q=%0d r=%0d, want spacing=5 q=3 r=0",
               k, quotient, remainder);
    else pass_cnt++;
  endtask

  task automatic test_exhaustive();
    logic [3:0] q, r, eq, er;
    logic z, ez;
    int lat, elat;
    int bad;
    bad = 0;
    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        repeat ($urandom_range(0, 3)) @(negedge clk);
        run_div(4'(a), 4'(b), q, r, z, lat);
        if (b == 0) begin
          eq = 4'd15; er = 4'(a); ez = 1'b1; elat = 0;
        end else begin
          eq = 4'(a / b); er = 4'(a % b); ez = 1'b0; elat = 4;
        end
        total_cnt++;
        if (lat !== elat || {q, r, z} !== {eq, er, ez}) begin
          bad++;
          $display("FAIL exh_%0d_%0d: got lat=%0d q=%0d r=%0d dbz=%b, want lat=%0d q=%0d r=%0d dbz=%b",
                   a, b, lat, q, r, z, elat, eq, er, ez);
        end else pass_cnt++;
      end
    end
    total_cnt++;
    if (overlap_cnt !== 0) $display("FAIL busy_done_overlap: got %0d cycles, want 0", overlap_cnt);
    else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_extremes();
    test_div_zero();
    test_back_to_back();
    test_exhaustive();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
